uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Serial-to-parallel UART receiver: samples i_rx at mid-bit, frames 8N1 or 8E1/8O1 bytes
//  (LSB first) and hands each good byte to the host through a valid/ready holding register.
//  It is the receiving end of the UART link whose transmit side shares the same ctrl/status and FIFO.
//  It reports framing, parity and overrun errors, and drives o_rts for hardware flow control.
// PARAMETERS
//  ClksPerBit  868  i_clk cycles per bit (100 MHz / 115200); must be >= 4
//  ParityEn    0    1 = a parity bit follows the data bits
//  ParityOdd   0    with ParityEn=1: 1 = odd parity, 0 = even parity
// PORTS
//  i_clk         in   1  clock; all logic is on the rising edge
//  i_rst         in   1  asynchronous, active-high reset
//  i_rx          in   1  serial line, asynchronous, idles high
//  o_rx_data     out  8  received byte; stable while o_rx_valid=1
//  o_rx_valid    out  1  holding register full
//  i_rx_ready    in   1  host accepts the byte when o_rx_valid & i_rx_ready
//  o_frame_err   out  1  1-cycle pulse: stop bit sampled low
//  o_parity_err  out  1  1-cycle pulse: parity mismatch
//  o_overrun     out  1  1-cycle pulse: good byte dropped because the holding register is full
//  o_rts         out  1  1 = peer may send (= ~o_rx_valid)
// BEHAVIOUR
//  Reset values
//  - Sync flops = 1. State = IDLE. Counters = 0. o_rx_data = 0.
//  - o_rx_valid = 0, error pulses = 0, o_rts = 1.
//  Input and counters
//  - i_rx passes through a 2-flop synchronizer to give rx_s; all decisions use rx_s.
//  - clk_cnt is $clog2(ClksPerBit) bits wide. HALF = ClksPerBit/2 - 1 (integer divide). FULL = ClksPerBit - 1.
//  - bit_idx is 3 bits.
//  FSM
//  - IDLE:   when rx_s = 0, go to START with clk_cnt = 0.
//  - START:  count to HALF. At HALF: if rx_s = 0, go to DATA with clk_cnt = 0 and bit_idx = 0;
//            otherwise it was a glitch, go to IDLE with no error.
//  - DATA:   at FULL, shift rx_s into shreg[bit_idx] and reset clk_cnt.
//            After bit_idx = 7, go to PARITY if ParityEn = 1, else to STOP.
//  - PARITY: at FULL, par_bad = (^shreg ^ rx_s) != ParityOdd. Go to STOP.
//  - STOP:   at FULL, sample the stop bit.
//      - rx_s = 0: pulse o_frame_err and go to BREAK; the byte is discarded.
//      - rx_s = 1 and par_bad: pulse o_parity_err and go to IDLE; the byte is discarded.
//      - rx_s = 1 and no error: deliver the byte and go to IDLE.
//  - BREAK:  wait for rx_s = 1, then go to IDLE. A held-low line therefore never re-triggers a start.
//  Delivery (in the cycle of the stop-bit sample)
//  - If o_rx_valid = 0, or o_rx_valid & i_rx_ready this cycle: load o_rx_data, and o_rx_valid = 1
//    next cycle. Back-to-back delivery never drops a byte.
//  - Otherwise: pulse o_overrun. The old byte is kept and the new byte is lost.
//  Handshake and latency
//  - A handshake with no delivery clears o_rx_valid on the next cycle.
//  - o_rx_data changes only on a load.
//  - Latency from the i_rx falling edge of the start bit to o_rx_valid = 1 is
//    2 + 1 + HALF + (9 + ParityEn) * ClksPerBit + 1 cycles (+-1 for synchronizer phase).
//  - Error pulses are exactly 1 cycle and mutually exclusive.
//  Reset mid-frame
//  - Asserting i_rst mid-frame aborts the frame immediately. After release the FSM waits in IDLE
//    for the next falling rx_s; a partially seen frame may decode as a glitch or as a frame error.
// TESTING  (ClksPerBit = 16 unless stated)
//  1. Send 0xA5 in 8N1, i_rx_ready = 1
//     -> o_rx_valid pulses 1 cycle with o_rx_data = 0xA5, no error pulses, o_rts dips low for 1 cycle.
//  2. Hold i_rx_ready = 0 and send 0x3C then 0xC3
//     -> 0x3C is held, o_overrun pulses at the stop sample of 0xC3, and o_rx_data stays 0x3C.
//     Then raise i_rx_ready -> valid clears next cycle.
//  3. Send 0x55 with the stop bit driven low, then hold i_rx low for 40 cycles, then high
//     -> one o_frame_err pulse, no o_rx_valid, no further start detected until i_rx returns high.
//  4. Drive i_rx low for 5 cycles only (glitch)
//     -> FSM returns to IDLE, no outputs change.
//     Then send 0x01 -> 0x01 received.
//  5. ParityEn = 1, ParityOdd = 0: send 0x07 with parity bit 1 -> byte delivered.
//     Send 0x07 with parity bit 0 -> o_parity_err pulse, no delivery.
//  6. Assert i_rst in the middle of DATA while receiving 0xFF
//     -> outputs take reset values immediately, and a following clean 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, 8N1/8E1/8O1 framing,
// valid/ready holding register with overrun, frame and parity error pulses.
`timescale 1ns/1ps
module uart_rx_core #(
   parameter int ClksPerBit = 868,
   parameter int ParityEn   = 0,
   parameter int ParityOdd  = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_overrun,
   output logic       o_rts
);

   localparam int            CW      = $clog2(ClksPerBit);
   localparam logic [CW-1:0] HALF    = CW'(ClksPerBit / 2 - 1);
   localparam logic [CW-1:0] FULL    = CW'(ClksPerBit - 1);
   localparam logic          PAR_EN  = (ParityEn != 0);
   localparam logic          PAR_ODD = (ParityOdd != 0);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   function automatic logic parity_bad(input logic [7:0] d, input logic p);
      return ((^d) ^ p) != PAR_ODD;
   endfunction

   logic          rx_p0, rx_p1, rx_s;
   state_t        state, state_n;
   logic [CW-1:0] clk_cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_bad, par_bad_n;
   logic          load, valid_n, frame_n, perr_n, ovr_n;

   assign rx_s  = rx_p1;
   assign o_rts = ~o_rx_valid;

   // synchronizer stage: rx_p0 -> rx_p1
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= i_rx;
         rx_p1 <= rx_p0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         par_bad      <= 1'b0;
         o_rx_data    <= '0;
         o_rx_valid   <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         state        <= state_n;
         clk_cnt      <= cnt_n;
         bit_idx      <= bit_n;
         shreg        <= shreg_n;
         par_bad      <= par_bad_n;
         o_rx_valid   <= valid_n;
         o_frame_err  <= frame_n;
         o_parity_err <= perr_n;
         o_overrun    <= ovr_n;
         if (load) o_rx_data <= shreg;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = clk_cnt + CW'(1);
      bit_n     = bit_idx;
      shreg_n   = shreg;
      par_bad_n = par_bad;
      load      = 1'b0;
      frame_n   = 1'b0;
      perr_n    = 1'b0;
      ovr_n     = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = S_START;
         end
         S_START: begin
            if (clk_cnt == HALF) begin
               cnt_n     = '0;
               bit_n     = '0;
               par_bad_n = 1'b0;
               state_n   = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (clk_cnt == FULL) begin
               cnt_n            = '0;
               shreg_n[bit_idx] = rx_s;
               bit_n            = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = PAR_EN ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (clk_cnt == FULL) begin
               cnt_n     = '0;
               par_bad_n = parity_bad(shreg, rx_s);
               state_n   = S_STOP;
            end
         end
         S_STOP: begin
            if (clk_cnt == FULL) begin
               cnt_n   = '0;
               state_n = S_IDLE;
               if (!rx_s) begin
                  frame_n = 1'b1;
                  state_n = S_BREAK;
               end else if (par_bad) begin
                  perr_n = 1'b1;
               end else if (!o_rx_valid || i_rx_ready) begin
                  load = 1'b1;
               end else begin
                  ovr_n = 1'b1;
               end
            end
         end
         S_BREAK: begin
            // a line held low must return high before a new start can be seen
            cnt_n = '0;
            if (rx_s) state_n = S_IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = S_IDLE;
         end
      endcase

      valid_n = o_rx_valid;
      if (load) valid_n = 1'b1;
      else if (o_rx_valid && i_rx_ready) valid_n = 1'b0;
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an 8N1 instance and an 8E1 instance at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_core;
   localparam int         CPB      = 16;
   localparam logic [1:0] EV_DATA  = 2'd0;
   localparam logic [1:0] EV_FRAME = 2'd1;
   localparam logic [1:0] EV_PAR   = 2'd2;
   localparam logic [1:0] EV_OVR   = 2'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
   logic [7:0] d0, d1;
   logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, rts0, rts1;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [9:0] q0[$];
   logic [9:0] q1[$];

   always #5 clk = ~clk;

   uart_rx_core #(.ClksPerBit(CPB), .ParityEn(0), .ParityOdd(0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_rx(rx0), .o_rx_data(d0), .o_rx_valid(v0),
      .i_rx_ready(rdy0), .o_frame_err(fe0), .o_parity_err(pe0), .o_overrun(ov0), .o_rts(rts0));

   uart_rx_core #(.ClksPerBit(CPB), .ParityEn(1), .ParityOdd(0)) u_par (
      .i_clk(clk), .i_rst(rst), .i_rx(rx1), .o_rx_data(d1), .o_rx_valid(v1),
      .i_rx_ready(rdy1), .o_frame_err(fe1), .o_parity_err(pe1), .o_overrun(ov1), .o_rts(rts1));

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void see_event(int inst, logic [1:0] kind, logic [7:0] data);
      logic [9:0] e;
      n_checks++;
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
         n_fail++;
         $display("FAIL unexpected_event inst%0d: got kind %0d data 0x%0h, expected no event",
                  inst, kind, data);
         return;
      end
      if (inst == 0) e = q0.pop_front();
      else           e = q1.pop_front();
      if (e[9:8] !== kind || ((kind == EV_DATA || kind == EV_OVR) && e[7:0] !== data)) begin
         n_fail++;
         $display("FAIL event inst%0d: got kind %0d data 0x%0h, expected kind %0d data 0x%0h",
                  inst, kind, data, e[9:8], e[7:0]);
      end
   endfunction

   // monitor: every DUT output event is matched against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (fe0) see_event(0, EV_FRAME, d0);
         if (pe0) see_event(0, EV_PAR, d0);
         if (ov0) see_event(0, EV_OVR, d0);
         if (v0 && rdy0) begin
            see_event(0, EV_DATA, d0);
            check("rts0_low_while_valid", 32'(rts0), 32'd0);
         end
         if (fe1) see_event(1, EV_FRAME, d1);
         if (pe1) see_event(1, EV_PAR, d1);
         if (ov1) see_event(1, EV_OVR, d1);
         if (v1 && rdy1) begin
            see_event(1, EV_DATA, d1);
            check("rts1_low_while_valid", 32'(rts1), 32'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_rx(input int inst, input logic b);
      if (inst == 0) rx0 = b;
      else           rx1 = b;
   endtask

   task automatic send(input int inst, input logic [7:0] data, input logic par_en,
                       input logic par, input logic stop, input int idle);
      set_rx(inst, 1'b0);
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         set_rx(inst, data[i]);
         tick(CPB);
      end
      if (par_en) begin
         set_rx(inst, par);
         tick(CPB);
      end
      set_rx(inst, stop);
      tick(CPB);
      if (idle > 0) begin
         set_rx(inst, 1'b1);
         tick(idle);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid0"}, 32'(v0), 32'd0);
      check({tag, "_rts0"}, 32'(rts0), 32'd1);
      check({tag, "_data0"}, 32'(d0), 32'd0);
      check({tag, "_errs0"}, 32'({fe0, pe0, ov0}), 32'd0);
      check({tag, "_valid1"}, 32'(v1), 32'd0);
      check({tag, "_rts1"}, 32'(rts1), 32'd1);
      check({tag, "_errs1"}, 32'({fe1, pe1, ov1}), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(5);

      // 1: single byte, host always ready
      q0.push_back({EV_DATA, 8'hA5});
      send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 2 * CPB);
      check("t1_valid_cleared", 32'(v0), 32'd0);
      check("t1_rts_high", 32'(rts0), 32'd1);
      check("t1_queue_empty", 32'(q0.size()), 32'd0);

      // 2: host stalled, second byte overruns
      rdy0 = 1'b0;
      q0.push_back({EV_OVR, 8'h3C});
      q0.push_back({EV_DATA, 8'h3C});
      send(0, 8'h3C, 1'b0, 1'b0, 1'b1, 2 * CPB);
      check("t2_valid_held", 32'(v0), 32'd1);
      check("t2_rts_low", 32'(rts0), 32'd0);
      send(0, 8'hC3, 1'b0, 1'b0, 1'b1, 2 * CPB);
      check("t2_data_kept", 32'(d0), 32'h3C);
      check("t2_valid_still", 32'(v0), 32'd1);
      rdy0 = 1'b1;
      tick(1);
      check("t2_valid_cleared", 32'(v0), 32'd0);
      tick(CPB);
      check("t2_queue_empty", 32'(q0.size()), 32'd0);

      // 3: stop bit low, line held low (break), then a clean byte
      q0.push_back({EV_FRAME, 8'h00});
      send(0, 8'h55, 1'b0, 1'b0, 1'b0, 0);
      tick(40);
      set_rx(0, 1'b1);
      tick(20 * CPB);
      check("t3_no_valid", 32'(v0), 32'd0);
      check("t3_queue_empty", 32'(q0.size()), 32'd0);
      q0.push_back({EV_DATA, 8'h5A});
      send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 2 * CPB);
      check("t3_after_break_empty", 32'(q0.size()), 32'd0);

      // 4: short glitch, then a real byte
      set_rx(0, 1'b0);
      tick(5);
      set_rx(0, 1'b1);
      tick(12 * CPB);
      check("t4_glitch_no_valid", 32'(v0), 32'd0);
      check("t4_glitch_data", 32'(d0), 32'h5A);
      q0.push_back({EV_DATA, 8'h01});
      send(0, 8'h01, 1'b0, 1'b0, 1'b1, 2 * CPB);
      check("t4_queue_empty", 32'(q0.size()), 32'd0);

      // 5: even parity instance, good then bad parity bit
      q1.push_back({EV_DATA, 8'h07});
      send(1, 8'h07, 1'b1, 1'b1, 1'b1, 2 * CPB);
      check("t5_good_data", 32'(d1), 32'h07);
      q1.push_back({EV_PAR, 8'h00});
      send(1, 8'h07, 1'b1, 1'b0, 1'b1, 2 * CPB);
      check("t5_bad_no_valid", 32'(v1), 32'd0);
      check("t5_queue_empty", 32'(q1.size()), 32'd0);

      // 6: reset in the middle of 0xFF data bits, then a clean byte
      check("t6_data_before", 32'(d0), 32'h01);
      set_rx(0, 1'b0);
      tick(CPB);
      set_rx(0, 1'b1);
      tick(3 * CPB + 5);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("t6_midframe");
      tick(2);
      rst = 1'b0;
      tick(8 * CPB);
      check("t6_idle_no_valid", 32'(v0), 32'd0);
      q0.push_back({EV_DATA, 8'h81});
      send(0, 8'h81, 1'b0, 1'b0, 1'b1, 2 * CPB);
      check("t6_queue_empty", 32'(q0.size()), 32'd0);
      check("final_q1_empty", 32'(q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
